// File: rtl/bsg_chip_hb_reset_seq_if.sv
// Tag-side bundle for the HammerBlade reset and cord sequencer.
// The master drives tag requests; the slave returns resets and cords.
interface bsg_chip_hb_reset_seq_if #(
  parameter int num_domains_p = 3,
  parameter int num_dest_p    = 2,
  parameter int cord_width_p  = 16
) ();

  logic                                   tag_reset_i;
  logic [num_dest_p-1:0][cord_width_p-1:0] dest_cord_i;
  logic [num_dest_p-1:0]                  dest_cord_new_i;
  logic [num_domains_p-1:0]               domain_reset_o;
  logic [num_dest_p-1:0][cord_width_p-1:0] dest_cord_o;
  logic                                   ready_o;
  logic                                   cord_err_o;

  modport master (
    output tag_reset_i,
    output dest_cord_i,
    output dest_cord_new_i,
    input  domain_reset_o,
    input  dest_cord_o,
    input  ready_o,
    input  cord_err_o
  );

  modport slave (
    input  tag_reset_i,
    input  dest_cord_i,
    input  dest_cord_new_i,
    output domain_reset_o,
    output dest_cord_o,
    output ready_o,
    output cord_err_o
  );

endinterface

// File: rtl/bsg_chip_hb_reset_seq.sv
// Staged reset release and destination-cord registers for the core complex.
// Define BSG_HB_RESET_SEQ_CORD_LOCK_EN to accept cord updates only in ASSERT.
module bsg_chip_hb_reset_seq #(
  parameter int num_domains_p   = 3,
  parameter int num_dest_p      = 2,
  parameter int cord_width_p    = 16,
  parameter int assert_cycles_p = 4,
  parameter int stage_cycles_p  = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bsg_chip_hb_reset_seq_if.slave  bus
);

  localparam int max_lp =
    (assert_cycles_p > stage_cycles_p) ? assert_cycles_p : stage_cycles_p;
  localparam int cnt_w_lp = $clog2(max_lp + 1);
  localparam int idx_w_lp = $clog2(num_domains_p + 1);

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_e;

  state_e                state_r, state_n;
  logic [cnt_w_lp-1:0]   cnt_r, cnt_n;
  logic [idx_w_lp-1:0]   idx_r, idx_n;
  logic [num_domains_p-1:0] dom_r, dom_n;
  logic                  ready_r, ready_n;

  logic [num_dest_p-1:0][cord_width_p-1:0] cord_r, cord_n;
  logic                  err_r, err_n;
  logic                  accept;

  // State, counters and registered reset outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= S_ASSERT;
      cnt_r   <= '0;
      idx_r   <= '0;
      dom_r   <= '1;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      dom_r   <= dom_n;
      ready_r <= ready_n;
    end
  end

  // Sequencing: hold-off count, then one domain per stage interval.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    unique case (state_r)
      S_ASSERT: begin
        if (bus.tag_reset_i) begin
          cnt_n = '0;
        end else if (cnt_r == cnt_w_lp'(assert_cycles_p - 1)) begin
          state_n = S_RELEASE;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt_r + cnt_w_lp'(1);
        end
      end
      S_RELEASE: begin
        if (bus.tag_reset_i) begin
          state_n = S_ASSERT;
          cnt_n   = '0;
          idx_n   = '0;
        end else if (cnt_r == cnt_w_lp'(stage_cycles_p - 1)) begin
          cnt_n = '0;
          idx_n = idx_r + idx_w_lp'(1);
          if (idx_r == idx_w_lp'(num_domains_p - 1))
            state_n = S_RUN;
        end else begin
          cnt_n = cnt_r + cnt_w_lp'(1);
        end
      end
      S_RUN: begin
        if (bus.tag_reset_i) begin
          state_n = S_ASSERT;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      default: begin
        state_n = S_ASSERT;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  // Next reset outputs: domains below idx are released in RELEASE.
  always_comb begin
    dom_n   = '1;
    ready_n = (state_n == S_RUN);
    for (int d = 0; d < num_domains_p; d++) begin
      if (state_n == S_RUN)
        dom_n[d] = 1'b0;
      else if (state_n == S_RELEASE)
        dom_n[d] = !(idx_w_lp'(d) < idx_n);
    end
  end

`ifdef BSG_HB_RESET_SEQ_CORD_LOCK_EN
  assign accept = (state_r == S_ASSERT);
`else
  assign accept = 1'b1;
`endif

  // Per-channel cord capture; a refused update raises the sticky flag.
  always_comb begin
    cord_n = cord_r;
    err_n  = err_r;
    for (int i = 0; i < num_dest_p; i++) begin
      if (bus.dest_cord_new_i[i]) begin
        if (accept)
          cord_n[i] = bus.dest_cord_i[i];
        else
          err_n = 1'b1;
      end
    end
  end

  // Cord and error registers.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      cord_r <= '0;
      err_r  <= 1'b0;
    end else begin
      cord_r <= cord_n;
      err_r  <= err_n;
    end
  end

  assign bus.domain_reset_o = dom_r;
  assign bus.ready_o        = ready_r;
  assign bus.dest_cord_o    = cord_r;
  assign bus.cord_err_o     = err_r;

endmodule

// File: tb/tb_bsg_chip_hb_reset_seq.sv
// Directed and random checks of bsg_chip_hb_reset_seq against a
// release-time model built on the length of the current tag-low run.
module tb_bsg_chip_hb_reset_seq;

  localparam int ND = 3;
  localparam int NC = 2;
  localparam int CW = 16;
  localparam int AC = 4;
  localparam int SC = 8;

`ifdef BSG_HB_RESET_SEQ_CORD_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bsg_chip_hb_reset_seq_if #(
    .num_domains_p(ND),
    .num_dest_p(NC),
    .cord_width_p(CW)
  ) bus ();

  bsg_chip_hb_reset_seq #(
    .num_domains_p(ND),
    .num_dest_p(NC),
    .cord_width_p(CW),
    .assert_cycles_p(AC),
    .stage_cycles_p(SC)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Model: number of consecutive sampled tag-low cycles since the
  // last tag request or chip reset; all outputs follow from it.
  int low_run = 0;
  logic [NC-1:0][CW-1:0] m_cord = '0;
  logic m_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rn, input logic tag,
                      input logic [NC-1:0] nw,
                      input logic [NC-1:0][CW-1:0] cd);
    logic in_assert;
    logic [ND-1:0] ed;
    reset_n = rn;
    bus.tag_reset_i = tag;
    bus.dest_cord_new_i = nw;
    bus.dest_cord_i = cd;
    @(posedge clk);
    if (!rn) begin
      low_run = 0;
      m_cord = '0;
      m_err = 1'b0;
    end else begin
      in_assert = (low_run < AC);
      for (int i = 0; i < NC; i++) begin
        if (nw[i]) begin
          if (!LOCK || in_assert) m_cord[i] = cd[i];
          else m_err = 1'b1;
        end
      end
      if (tag) low_run = 0;
      else if (low_run < 100000) low_run++;
    end
    #1;
    for (int k = 0; k < ND; k++)
      ed[k] = !(low_run >= AC + (k + 1) * SC);
    check("model_dom", bus.domain_reset_o, ed);
    check("model_ready", bus.ready_o, low_run >= AC + ND * SC);
    for (int i = 0; i < NC; i++)
      check($sformatf("model_cord%0d", i), bus.dest_cord_o[i], m_cord[i]);
    check("model_err", bus.cord_err_o, m_err);
  endtask

  task automatic idle(input logic tag);
    step(1'b1, tag, '0, '0);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.tag_reset_i = 1'b1;
    bus.dest_cord_new_i = '0;
    bus.dest_cord_i = '0;

    step(1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b0, '0, '0);
    check("rst_dom", bus.domain_reset_o, 3'b111);
    check("rst_ready", bus.ready_o, 1'b0);
    check("rst_cord", bus.dest_cord_o, 32'h0);
    check("rst_err", bus.cord_err_o, 1'b0);

    // Cord load while in ASSERT.
    idle(1'b1);
    step(1'b1, 1'b1, 2'b10, 32'h00A5_5555);
    check("assert_cord1", bus.dest_cord_o[1], 16'h00A5);
    check("assert_cord0", bus.dest_cord_o[0], 16'h0000);
    check("assert_err", bus.cord_err_o, 1'b0);

    // Nominal release.
    for (int i = 0; i < 5; i++) idle(1'b1);
    for (int n = 1; n <= 30; n++) begin
      idle(1'b0);
      case (n)
        11: check("nom_t11", bus.domain_reset_o, 3'b111);
        12: check("nom_t12", bus.domain_reset_o, 3'b110);
        19: check("nom_t19", bus.domain_reset_o, 3'b110);
        20: check("nom_t20", bus.domain_reset_o, 3'b100);
        27: check("nom_t27_ready", bus.ready_o, 1'b0);
        28: begin
          check("nom_t28", bus.domain_reset_o, 3'b000);
          check("nom_t28_ready", bus.ready_o, 1'b1);
        end
        default: ;
      endcase
    end

    // Glitch restart.
    idle(1'b1);
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    for (int n = 1; n <= 12; n++) begin
      idle(1'b0);
      if (n < 12) check("glitch_hold", bus.domain_reset_o, 3'b111);
      else check("glitch_t12", bus.domain_reset_o, 3'b110);
    end

    // Mid-sequence abort.
    idle(1'b1);
    for (int n = 1; n <= 15; n++) idle(1'b0);
    check("abort_t15", bus.domain_reset_o, 3'b110);
    idle(1'b1);
    check("abort_t16", bus.domain_reset_o, 3'b111);
    check("abort_ready", bus.ready_o, 1'b0);
    for (int n = 1; n <= 28; n++) begin
      idle(1'b0);
      if (n == 12) check("reabort_t12", bus.domain_reset_o, 3'b110);
      if (n == 20) check("reabort_t20", bus.domain_reset_o, 3'b100);
      if (n == 28) check("reabort_t28", bus.ready_o, 1'b1);
    end

    // Cord update while in RUN.
    step(1'b1, 1'b0, 2'b01, 32'h0000_1234);
    check("run_cord0", bus.dest_cord_o[0], LOCK ? 16'h0000 : 16'h1234);
    check("run_cord1", bus.dest_cord_o[1], 16'h00A5);
    check("run_err", bus.cord_err_o, LOCK);
    idle(1'b1);
    idle(1'b0);
    check("run_err_sticky", bus.cord_err_o, LOCK);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      logic rn;
      logic tg;
      logic [NC-1:0] nw;
      logic [NC-1:0][CW-1:0] cd;
      rn = ($urandom_range(0, 199) != 0);
      tg = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NC; i++) begin
        nw[i] = ($urandom_range(0, 7) == 0);
        cd[i] = CW'($urandom);
      end
      step(rn, tg, nw, cd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bsg_chip_hb_reset_seq.md
# bsg_chip_hb_reset_seq

Parametrised reset and destination-cord sequencer for the HammerBlade chip core complex. It generalises the single tag-driven reset and the pair of tag-driven wormhole destination cords into N staged reset domains and M cord channels. Reset release is ordered: IO adapters first, then the pod array, then the tieoffs, with a programmable spacing between them. The block sits between the bsg_tag clients and every reset and `dest_wh_cord` consumer in the core complex.

## Interface
- `num_domains_p`, default 3: number of reset domains; domain 0 releases first.
- `num_dest_p`, default 2: number of destination-cord channels (W, E).
- `cord_width_p`, default 16: width of each cord (set to `wh_cord_width_gp`).
- `assert_cycles_p`, default 4: minimum number of consecutive cycles with the tag reset low before release starts; must be ≥1.
- `stage_cycles_p`, default 8: cycles between successive domain releases; must be ≥1.

Ports:
- `clk_i`  in  1  core clock (`hb_clk`).
- `reset_n_i`  in  1  synchronous, active-low reset.
- `tag_reset_i`  in  1  level reset request from the tag client payload.
- `dest_cord_i`  in  num_dest_p×cord_width_p  cord values from the tag clients.
- `dest_cord_new_i`  in  num_dest_p  one-cycle pulse per channel when new tag data arrives.
- `domain_reset_o`  out  num_domains_p  active-high reset per domain; registered.
- `dest_cord_o`  out  num_dest_p×cord_width_p  registered cords.
- `ready_o`  out  1  high when all domains are released (state RUN).
- `cord_err_o`  out  1  sticky flag: a cord update was dropped.

## Operation
States are ASSERT, RELEASE and RUN. The block keeps a counter `cnt_r` of width `$clog2(max(assert_cycles_p,stage_cycles_p)+1)` and a domain index `idx_r` of width `$clog2(num_domains_p+1)`.

Values while `reset_n_i`=0:
- state = ASSERT
- `cnt_r` = 0, `idx_r` = 0
- `domain_reset_o` = all 1
- `dest_cord_o` = 0
- `ready_o` = 0, `cord_err_o` = 0

ASSERT:
- All domains are held in reset.
- If `tag_reset_i`=1, `cnt_r` clears to 0.
- Otherwise `cnt_r` increments.
- On the cycle where `tag_reset_i`=0 and `cnt_r`==`assert_cycles_p`-1, the next state is RELEASE with `cnt_r`=0 and `idx_r`=0.

RELEASE:
- `cnt_r` increments every cycle.
- On the cycle where `cnt_r`==`stage_cycles_p`-1, `domain_reset_o[idx_r]` clears on the next edge, `idx_r` increments and `cnt_r` returns to 0.
- After the last domain is released, the next state is RUN and `ready_o` rises on the same edge as the last domain release.

RUN:
- All resets are low and `ready_o`=1.

Abort from any state:
- `tag_reset_i`=1 in RELEASE or RUN sends the block to ASSERT on the next edge.
- On that edge all `domain_reset_o` return to 1, `ready_o` drops to 0, and `cnt_r` and `idx_r` clear.
- A reset request in the middle of RELEASE therefore re-asserts domains that were already released.

Cords:
- `dest_cord_o[i]` loads `dest_cord_i[i]` on the edge following a `dest_cord_new_i[i]` pulse, subject to the acceptance rule in Configuration.
- Channels are independent; pulses on several channels in the same cycle are all handled.

## Timing
- Every output is a flop; there is no combinational path from input to output.
- Latency from the first sampled `tag_reset_i`=0 (cycle T) to release of domain k is `assert_cycles_p` + (k+1)·`stage_cycles_p` cycles.
- Latency from `tag_reset_i`=1 to all resets asserted is 1 cycle.
- Cord update latency is 1 cycle.
- A glitch on `tag_reset_i` shorter than `assert_cycles_p` cycles in ASSERT restarts the count.
- `tag_reset_i`=1 together with `dest_cord_new_i` while in RUN: the state observed in that cycle (RUN) decides whether the cord is accepted.

## Configuration
`BSG_HB_RESET_SEQ_CORD_LOCK_EN`:
- Defined: a cord update is accepted only when the current state is ASSERT. In RELEASE or RUN the update is dropped, `dest_cord_o` is unchanged, and `cord_err_o` is set. `cord_err_o` stays set until `reset_n_i`=0.
- Undefined: cord updates are accepted in every state and `cord_err_o` is tied to 0.

## Test plan
- **Nominal release.** `reset_n_i` low then high, with `tag_reset_i`=1 for 5 cycles, then 0 from cycle T. Required: `domain_reset_o[0]` falls at T+12, `[1]` at T+20, `[2]` at T+28; `ready_o` rises at T+28.
- **Glitch restart.** `tag_reset_i` low for 3 cycles, high for 1 cycle, then low from cycle T. Required: no release before T+12; `domain_reset_o[0]` falls exactly at T+12.
- **Mid-sequence abort.** Raise `tag_reset_i` at T+15 (domain 0 released, domain 1 not yet). Required: at T+16 all `domain_reset_o`=3'b111 and `ready_o`=0; lowering `tag_reset_i` again gives the full sequence timing from the new T.
- **Cord load in ASSERT.** `dest_cord_i[1]`=16'h00A5 with `dest_cord_new_i`=2'b10. Required: `dest_cord_o[1]`=16'h00A5 on the next cycle, `dest_cord_o[0]` unchanged, `cord_err_o`=0.
- **Cord in RUN, lock defined.** Pulse a cord update of 16'h1234 on channel 0 while in RUN. Required: `dest_cord_o[0]` unchanged, `cord_err_o`=1, and the flag stays 1 after a `tag_reset_i` cycle.
- **Cord in RUN, lock undefined.** Same stimulus as above. Required: `dest_cord_o[0]`=16'h1234 after 1 cycle, `cord_err_o`=0.
